// File: rtl/rv32_pkg.sv
// Shared RV32 constants and types for the writeback unit, register file and decode.
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    // Which producer won the write port this cycle
    typedef enum logic [1:0] {
        SrcNone,
        SrcAlu,
        SrcLsu
    } wb_src_e;

    // x0 is hardwired to zero: never written, never busy
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/rv32_writeback_unit_if.sv
// Bundle of all writeback-unit traffic: issue, ALU/LSU result handshakes,
// regfile write port and decode hazard/bypass queries.
// slave: the writeback unit. master: the surrounding pipeline.
interface rv32_writeback_unit_if;
    import rv32_pkg::*;

    logic      iss_valid;
    reg_addr_t iss_rd;

    logic      alu_valid;
    logic      alu_ready;
    reg_addr_t alu_rd;
    xlen_t     alu_data;

    logic      lsu_valid;
    logic      lsu_ready;
    reg_addr_t lsu_rd;
    xlen_t     lsu_data;

    logic      rf_we;
    reg_addr_t rf_rd_addr;
    xlen_t     rf_val_rd;

    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      rs1_fwd_vld;
    xlen_t     rs1_fwd;
    logic      rs2_fwd_vld;
    xlen_t     rs2_fwd;

    modport slave (
        input  iss_valid, iss_rd,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_we, rf_rd_addr, rf_val_rd,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy, rs1_fwd_vld, rs1_fwd, rs2_fwd_vld, rs2_fwd
    );

    modport master (
        output iss_valid, iss_rd,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_we, rf_rd_addr, rf_val_rd,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy, rs1_fwd_vld, rs1_fwd, rs2_fwd_vld, rs2_fwd
    );

endinterface

// File: rtl/rv32_wb_scoreboard.sv
// Per-register busy scoreboard with two combinational read ports.
// An issue on the same edge as a commit to the same register keeps the bit set.
module rv32_wb_scoreboard
    import rv32_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      set_en_i,
    input  reg_addr_t set_addr_i,
    input  logic      clr_en_i,
    input  reg_addr_t clr_addr_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    output logic      rs1_busy_o,
    output logic      rs2_busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    // Next busy vector: clear on commit first, then set on issue so issue wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && !is_x0(set_addr_i)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/rv32_writeback_unit.sv
// Writeback unit: LSU-over-ALU arbiter, one registered regfile write per cycle,
// RAW scoreboard and optional writeback bypass.
// Optional feature macro: WB_BYPASS_EN (forward the in-flight regfile write to decode).
module rv32_writeback_unit
    import rv32_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    rv32_writeback_unit_if.slave  wb
);

    wb_src_e   src;
    logic      we_q, we_d;
    reg_addr_t addr_q, addr_d;
    xlen_t     data_q, data_d;
    logic      sb_rs1_busy, sb_rs2_busy;

    // Fixed-priority arbitration; readies are low while reset is asserted
    always_comb begin
        wb.lsu_ready = rst_n_i;
        wb.alu_ready = rst_n_i & ~wb.lsu_valid;
        src = SrcNone;
        if (wb.lsu_valid && wb.lsu_ready) begin
            src = SrcLsu;
        end else if (wb.alu_valid && wb.alu_ready) begin
            src = SrcAlu;
        end
    end

    // Next write-port state; x0 results are consumed without a write
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        unique case (src)
            SrcLsu: begin
                if (!is_x0(wb.lsu_rd)) begin
                    we_d   = 1'b1;
                    addr_d = wb.lsu_rd;
                    data_d = wb.lsu_data;
                end
            end
            SrcAlu: begin
                if (!is_x0(wb.alu_rd)) begin
                    we_d   = 1'b1;
                    addr_d = wb.alu_rd;
                    data_d = wb.alu_data;
                end
            end
            default: ;
        endcase
    end

    // Regfile write-port register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wb.rf_we      = we_q;
    assign wb.rf_rd_addr = addr_q;
    assign wb.rf_val_rd  = data_q;

    rv32_wb_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .set_en_i   (wb.iss_valid),
        .set_addr_i (wb.iss_rd),
        .clr_en_i   (we_q),
        .clr_addr_i (addr_q),
        .rs1_addr_i (wb.rs1_addr),
        .rs2_addr_i (wb.rs2_addr),
        .rs1_busy_o (sb_rs1_busy),
        .rs2_busy_o (sb_rs2_busy)
    );

`ifdef WB_BYPASS_EN
    logic rs1_hit, rs2_hit;

    // Forward the committing value; the source is no longer a hazard this cycle
    always_comb begin
        rs1_hit        = we_q && (addr_q == wb.rs1_addr) && !is_x0(wb.rs1_addr);
        rs2_hit        = we_q && (addr_q == wb.rs2_addr) && !is_x0(wb.rs2_addr);
        wb.rs1_fwd_vld = rs1_hit;
        wb.rs2_fwd_vld = rs2_hit;
        wb.rs1_fwd     = rs1_hit ? data_q : '0;
        wb.rs2_fwd     = rs2_hit ? data_q : '0;
        wb.rs1_busy    = sb_rs1_busy & ~rs1_hit;
        wb.rs2_busy    = sb_rs2_busy & ~rs2_hit;
    end
`else
    // No bypass: busy comes straight from the scoreboard
    always_comb begin
        wb.rs1_fwd_vld = 1'b0;
        wb.rs2_fwd_vld = 1'b0;
        wb.rs1_fwd     = '0;
        wb.rs2_fwd     = '0;
        wb.rs1_busy    = sb_rs1_busy;
        wb.rs2_busy    = sb_rs2_busy;
    end
`endif

endmodule

// File: tb/tb_rv32_writeback_unit.sv
// Self-checking bench for rv32_writeback_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the write port
// and busy table. Honours WB_BYPASS_EN the same way the design does.
module tb_rv32_writeback_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32_writeback_unit_if wb_if ();

    rv32_writeback_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .wb      (wb_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    // Model state: pending-write table and the last write presented to the regfile
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic check_port(input string tag, input logic [4:0] rs, input logic busy,
                              input logic vld, input logic [31:0] fwd);
        bit hit;
        hit = Bypass && m_we && (m_addr == rs) && (rs != 0);
        check_eq({tag, "_busy"}, busy, (m_busy[rs] && !hit));
        check_eq({tag, "_fwd_vld"}, vld, hit);
        check_eq({tag, "_fwd"}, fwd, hit ? m_data : 32'h0);
    endtask

    task automatic check_all();
        check_eq("lsu_ready", wb_if.lsu_ready, 1'b1);
        check_eq("alu_ready", wb_if.alu_ready, !wb_if.lsu_valid);
        check_eq("rf_we", wb_if.rf_we, m_we);
        if (m_we) begin
            check_eq("rf_addr", wb_if.rf_rd_addr, m_addr);
            check_eq("rf_data", wb_if.rf_val_rd, m_data);
        end
        check_port("rs1", wb_if.rs1_addr, wb_if.rs1_busy, wb_if.rs1_fwd_vld, wb_if.rs1_fwd);
        check_port("rs2", wb_if.rs2_addr, wb_if.rs2_busy, wb_if.rs2_fwd_vld, wb_if.rs2_fwd);
    endtask

    // What happens at the clock edge: commit retires, issue marks busy, winner is written
    task automatic model_edge();
        if (m_we) m_busy[m_addr] = 1'b0;
        if (wb_if.iss_valid && wb_if.iss_rd != 0) m_busy[wb_if.iss_rd] = 1'b1;
        m_we = 1'b0;
        if (wb_if.lsu_valid) begin
            if (wb_if.lsu_rd != 0) begin
                m_we = 1'b1; m_addr = wb_if.lsu_rd; m_data = wb_if.lsu_data;
            end
        end else if (wb_if.alu_valid) begin
            if (wb_if.alu_rd != 0) begin
                m_we = 1'b1; m_addr = wb_if.alu_rd; m_data = wb_if.alu_data;
            end
        end
    endtask

    // Inputs are set at posedge+1; check at +3, advance model, return at next posedge+1
    task automatic cycle();
        #2;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_if.iss_valid = 1'b0; wb_if.iss_rd = '0;
        wb_if.alu_valid = 1'b0; wb_if.alu_rd = '0; wb_if.alu_data = '0;
        wb_if.lsu_valid = 1'b0; wb_if.lsu_rd = '0; wb_if.lsu_data = '0;
        wb_if.rs1_addr  = '0;   wb_if.rs2_addr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_eq("rst_rf_we", wb_if.rf_we, 1'b0);
        check_eq("rst_rf_addr", wb_if.rf_rd_addr, 32'h0);
        check_eq("rst_rf_data", wb_if.rf_val_rd, 32'h0);
        check_eq("rst_alu_ready", wb_if.alu_ready, 1'b0);
        check_eq("rst_lsu_ready", wb_if.lsu_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ALU only
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd5; wb_if.alu_data = 32'h21;
        cycle();
        wb_if.alu_valid = 1'b0;
        check_eq("alu_only_we", wb_if.rf_we, 1'b1);
        check_eq("alu_only_addr", wb_if.rf_rd_addr, 32'd5);
        check_eq("alu_only_data", wb_if.rf_val_rd, 32'h21);
        cycle();

        // Collision: LSU first, ALU held and written one cycle later
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd3; wb_if.alu_data = 32'd546;
        wb_if.lsu_valid = 1'b1; wb_if.lsu_rd = 5'd4; wb_if.lsu_data = 32'hdead;
        cycle();
        wb_if.lsu_valid = 1'b0;
        check_eq("coll_lsu_addr", wb_if.rf_rd_addr, 32'd4);
        check_eq("coll_lsu_data", wb_if.rf_val_rd, 32'hdead);
        cycle();
        wb_if.alu_valid = 1'b0;
        check_eq("coll_alu_we", wb_if.rf_we, 1'b1);
        check_eq("coll_alu_addr", wb_if.rf_rd_addr, 32'd3);
        check_eq("coll_alu_data", wb_if.rf_val_rd, 32'd546);
        cycle();

        // x0 result consumed, no write
        wb_if.lsu_valid = 1'b1; wb_if.lsu_rd = 5'd0; wb_if.lsu_data = 32'd654;
        wb_if.rs1_addr = 5'd0;
        cycle();
        wb_if.lsu_valid = 1'b0;
        check_eq("x0_we", wb_if.rf_we, 1'b0);
        check_eq("x0_busy", wb_if.rs1_busy, 1'b0);
        cycle();

        // Scoreboard: issue rd=9, busy until commit; issue on commit edge keeps busy
        wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd9; wb_if.rs1_addr = 5'd9;
        cycle();
        wb_if.iss_valid = 1'b0;
        check_eq("sb_busy_after_issue", wb_if.rs1_busy, 1'b1);
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd9; wb_if.alu_data = 32'h99;
        cycle();
        wb_if.alu_valid = 1'b0;
        wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd9;
        cycle();
        wb_if.iss_valid = 1'b0;
        check_eq("sb_issue_wins", wb_if.rs1_busy, 1'b1);
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd9; wb_if.alu_data = 32'h98;
        cycle();
        wb_if.alu_valid = 1'b0;
        cycle();
        check_eq("sb_cleared", wb_if.rs1_busy, 1'b0);

        // Bypass of an in-flight write to rd=12
        wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd12; wb_if.rs2_addr = 5'd12;
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd12; wb_if.alu_data = 32'h55;
        cycle();
        wb_if.iss_valid = 1'b0; wb_if.alu_valid = 1'b0;
        check_eq("byp_rf_we", wb_if.rf_we, 1'b1);
        check_eq("byp_rs2_busy", wb_if.rs2_busy, Bypass ? 1'b0 : 1'b1);
        check_eq("byp_rs2_fwd_vld", wb_if.rs2_fwd_vld, Bypass);
        check_eq("byp_rs2_fwd", wb_if.rs2_fwd, Bypass ? 32'h55 : 32'h0);
        cycle();

        // Randomized traffic; sources hold their item until the model says it was taken
        for (int i = 0; i < 1500; i++) begin
            wb_if.iss_valid = ($urandom_range(0, 2) == 0);
            wb_if.iss_rd    = 5'($urandom_range(0, 15));
            wb_if.rs1_addr  = 5'($urandom_range(0, 15));
            wb_if.rs2_addr  = 5'($urandom_range(0, 15));
            if (!wb_if.alu_valid && $urandom_range(0, 1) == 1) begin
                wb_if.alu_valid = 1'b1;
                wb_if.alu_rd    = 5'($urandom_range(0, 15));
                wb_if.alu_data  = $urandom;
            end
            if (!wb_if.lsu_valid && $urandom_range(0, 2) == 0) begin
                wb_if.lsu_valid = 1'b1;
                wb_if.lsu_rd    = 5'($urandom_range(0, 15));
                wb_if.lsu_data  = $urandom;
            end
            cycle();
            if (wb_if.lsu_valid) wb_if.lsu_valid = 1'b0;
            else if (wb_if.alu_valid) wb_if.alu_valid = 1'b0;
        end
        idle_inputs();
        cycle();

        // Reset in the middle of a write to rd=7
        wb_if.iss_valid = 1'b1; wb_if.iss_rd = 5'd7; wb_if.rs1_addr = 5'd7;
        cycle();
        wb_if.iss_valid = 1'b0;
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd7; wb_if.alu_data = 32'h77;
        cycle();
        wb_if.alu_valid = 1'b0;
        check_eq("pre_rst_we", wb_if.rf_we, 1'b1);
        check_eq("pre_rst_busy7", wb_if.rs1_busy, Bypass ? 1'b0 : 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", wb_if.rf_we, 1'b0);
        check_eq("mid_rst_addr", wb_if.rf_rd_addr, 32'h0);
        check_eq("mid_rst_data", wb_if.rf_val_rd, 32'h0);
        check_eq("mid_rst_busy7", wb_if.rs1_busy, 1'b0);
        check_eq("mid_rst_fwd_vld", wb_if.rs1_fwd_vld, 1'b0);
        check_eq("mid_rst_lsu_ready", wb_if.lsu_ready, 1'b0);
        do_reset();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
